// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

    // Transmit FSM states, in the order a frame visits them.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Parity mode encodings for the PARITY parameter.
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Parity bit for a byte: even makes the total count of ones even, odd makes it odd.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..BPS_CNT-1 while a frame is active, ticks on the last count.
module uart_baud_cnt #(
    parameter int unsigned BPS_CNT = 434
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on frame start or when idle, wrap at the end of each bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = run && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_send.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_send
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned UART_BPS  = 115200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       send_en,
    input  logic [7:0] send_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;

    logic       en_d0;
    logic       en_d1;
    logic       start_flag;
    logic       frame_start;
    logic       bit_tick;

    tx_state_e  state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Two-stage sampling of send_en for rising-edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            en_d0 <= 1'b0;
            en_d1 <= 1'b0;
        end else begin
            en_d0 <= send_en;
            en_d1 <= en_d0;
        end
    end

    assign start_flag  = en_d0 & ~en_d1;
    // Requests arriving while busy are dropped, including the cycle busy falls.
    assign frame_start = start_flag & ~busy_q;

    uart_baud_cnt #(
        .BPS_CNT (BPS_CNT)
    ) u_baud_cnt (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clear    (frame_start),
        .run      (busy_q),
        .bit_tick (bit_tick)
    );

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    data_d     = send_data;
                    busy_d     = 1'b1;
                    txd_d      = 1'b0;
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    txd_d     = data_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            txd_d   = parity_bit(data_q, PARITY);
                            state_d = StParity;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = data_q[bit_idx_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    txd_d      = 1'b1;
                    stop_idx_d = 1'b0;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    if ((STOP_BITS == 2) && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset leaves the line idle high.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            data_q     <= 8'h00;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: four configurations driven in parallel against a frame-level model.
module tb_uart_send;

    localparam int BIT  = 434;
    localparam int LMAX = 11 * BIT;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       send_en = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic [3:0] txd;
    logic [3:0] tx_busy;
    logic [3:0] tx_done;

    integer checks = 0;
    integer failures = 0;

    always #5 sys_clk = ~sys_clk;

    // Instance 0: no parity, 1 stop; 1: odd parity; 2: even parity; 3: no parity, 2 stop.
    uart_send #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en), .send_data(send_data),
        .txd(txd[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_send #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .PARITY(1), .STOP_BITS(1)) u_o1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en), .send_data(send_data),
        .txd(txd[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_send #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en), .send_data(send_data),
        .txd(txd[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_send #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en), .send_data(send_data),
        .txd(txd[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    function automatic int cfg_par(input int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return (9 + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i)) * BIT;
    endfunction

    // Expected line level k cycles into a frame carrying byte d.
    function automatic logic exp_line(input int i, input logic [7:0] d, input int k);
        int slot;
        int ones;
        slot = k / BIT;
        ones = $countones(d);
        if (k >= frame_len(i)) return 1'b1;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (cfg_par(i) != 0 && slot == 9) begin
            if (cfg_par(i) == 1) return (ones % 2 == 0);
            return (ones % 2 == 1);
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input integer obs, input integer exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start one frame (by send_en edge or reset release) and check every cycle of all instances.
    // toggle_k >= 0 re-raises send_en at that cycle with data 0xFF; hold_k keeps send_en high.
    task automatic run_frame(input logic [7:0] d, input int toggle_k, input int hold_k,
                             input bit from_reset, input string name);
        int line_bad[4];
        int busy_bad[4];
        int done_bad[4];
        int busy_cnt[4];
        int done_cnt[4];
        int kmax;
        kmax = (hold_k > LMAX + 4) ? hold_k : LMAX + 4;
        for (int i = 0; i < 4; i++) begin
            line_bad[i] = -1; busy_bad[i] = -1; done_bad[i] = -1;
            busy_cnt[i] = 0;  done_cnt[i] = 0;
        end
        @(negedge sys_clk);
        send_data = d;
        if (from_reset) sys_rst = 1'b0;
        else send_en = 1'b1;
        @(negedge sys_clk);
        check($sformatf("%s_lat_busy", name), tx_busy, 0);
        check($sformatf("%s_lat_txd", name), txd, 4'hF);
        for (int k = 0; k < kmax; k++) begin
            @(negedge sys_clk);
            for (int i = 0; i < 4; i++) begin
                if (txd[i] !== exp_line(i, d, k) && line_bad[i] < 0) line_bad[i] = k;
                if (tx_busy[i] !== (k < frame_len(i)) && busy_bad[i] < 0) busy_bad[i] = k;
                if (tx_done[i] !== (k == frame_len(i)) && done_bad[i] < 0) done_bad[i] = k;
                if (tx_busy[i] === 1'b1) busy_cnt[i]++;
                if (tx_done[i] === 1'b1) done_cnt[i]++;
            end
            if (k == 5) send_data = 8'($urandom);
            if (toggle_k >= 0 && k == toggle_k - 3) send_en = 1'b0;
            if (toggle_k >= 0 && k == toggle_k) begin
                send_en = 1'b1;
                send_data = 8'hFF;
            end
            if (toggle_k < 0 && hold_k == 0 && k == 50) send_en = 1'b0;
        end
        send_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_line_first_bad%0d", name, i), line_bad[i], -1);
            check($sformatf("%s_busy_first_bad%0d", name, i), busy_bad[i], -1);
            check($sformatf("%s_done_first_bad%0d", name, i), done_bad[i], -1);
            check($sformatf("%s_busy_len%0d", name, i), busy_cnt[i], frame_len(i));
            check($sformatf("%s_done_cnt%0d", name, i), done_cnt[i], 1);
        end
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        int bad_busy;
        int bad_done;
        int bad_txd;

        // Reset state.
        repeat (3) @(negedge sys_clk);
        check("rst_txd", txd, 4'hF);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Directed bytes, then random ones.
        run_frame(8'h55, -1, 0, 1'b0, "b55");
        run_frame(8'h07, -1, 0, 1'b0, "b07");
        run_frame(8'hA3, -1, 0, 1'b0, "bA3");
        run_frame(8'($urandom), -1, 0, 1'b0, "rnd0");
        run_frame(8'($urandom), -1, 0, 1'b0, "rnd1");

        // Fresh send_en edge mid-frame is dropped.
        run_frame(8'h3C, 1000, 0, 1'b0, "coll");
        // Edge landing on the cycle busy falls (shortest config) is dropped too.
        run_frame(8'h81, frame_len(0) - 2, 0, 1'b0, "tail");
        // Level held high gives one frame only.
        run_frame(8'h96, -1, 20000, 1'b0, "hold");

        // Reset mid-frame aborts immediately, no resumption, no done pulse.
        @(negedge sys_clk);
        send_data = 8'h5A;
        send_en = 1'b1;
        repeat (2001) @(negedge sys_clk);
        check("abort_pre_busy", tx_busy, 4'hF);
        sys_rst = 1'b1;
        #1;
        check("abort_txd", txd, 4'hF);
        check("abort_busy", tx_busy, 0);
        check("abort_done", tx_done, 0);
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        bad_busy = 0;
        bad_done = 0;
        bad_txd = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge sys_clk);
            if (tx_busy !== 4'h0) bad_busy++;
            if (tx_done !== 4'h0) bad_done++;
            if (txd !== 4'hF) bad_txd++;
        end
        check("post_abort_busy_cycles", bad_busy, 0);
        check("post_abort_done_cycles", bad_done, 0);
        check("post_abort_txd_cycles", bad_txd, 0);

        // send_en already high when reset releases starts exactly one frame.
        @(negedge sys_clk);
        sys_rst = 1'b1;
        send_en = 1'b1;
        repeat (2) @(negedge sys_clk);
        run_frame(8'hC6, -1, 0, 1'b1, "rel");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_send.md
UART_SEND -- requirements
Module: uart_send

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, shall give the sys_clk frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, shall give the line baud rate.
REQ-003 Parameter PARITY, default 0, shall select 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1, shall select 1 or 2 stop bits.
REQ-005 sys_clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-006 sys_rst  input  1  shall be the reset: asynchronous, active-high.
REQ-007 send_en  input  1  shall be a level request; a rising edge starts a frame.
REQ-008 send_data  input  8  shall be the byte to transmit, sampled at frame start.
REQ-009 txd  output  1  shall be the serial line, idle high.
REQ-010 tx_busy  output  1  shall be high while a frame is in progress.
REQ-011 tx_done  output  1  shall be a one-cycle pulse at frame completion.

Function
REQ-012 BPS_CNT shall equal CLK_FREQ/UART_BPS (integer division); every bit shall last exactly BPS_CNT cycles.
REQ-013 send_en shall pass through two registers (en_d0, en_d1); start_flag = en_d0 & ~en_d1.
REQ-014 When start_flag is high and tx_busy is low, the next edge shall latch send_data, set tx_busy=1, drive txd=0 and enter START.
REQ-015 Latency: send_en first sampled high at edge N shall give txd=0 and tx_busy=1 after edge N+1.
REQ-016 FSM states shall be IDLE, START, DATA, PARITY, STOP; START->DATA after BPS_CNT cycles.
REQ-017 DATA shall send 8 bits LSB first with a 3-bit index; after bit 7: PARITY if PARITY!=0, else STOP.
REQ-018 Parity bit shall be ^data (even) or ~^data (odd) of the latched byte, held for one bit period.
REQ-019 STOP shall drive txd=1 for STOP_BITS*BPS_CNT cycles, then go to IDLE.
REQ-020 tx_busy shall stay high exactly (1+8+(PARITY!=0)+STOP_BITS)*BPS_CNT cycles.
REQ-021 tx_done shall pulse high for one cycle at the edge where tx_busy falls.
REQ-022 A start_flag while tx_busy=1 shall be dropped, not queued; a new frame needs a fresh rising edge after IDLE.
REQ-023 send_en held high continuously shall cause exactly one frame.
REQ-024 send_data changes during a frame shall not affect the frame in flight.
REQ-025 start_flag in the same cycle tx_busy falls shall be ignored (busy still sampled high).

Reset
REQ-026 sys_rst high shall immediately force txd=1, tx_busy=0, tx_done=0, state IDLE, counters and en_d0/en_d1 to 0.
REQ-027 Reset mid-frame shall abort the frame; no partial resumption after release.
REQ-028 With send_en already high at reset release, one frame shall start (edge seen via en_d1=0).

Structure
REQ-029 Package uart_pkg shall hold the FSM state enum and parity encodings (PAR_NONE/PAR_ODD/PAR_EVEN).
REQ-030 Sub-module uart_baud_cnt shall count 0..BPS_CNT-1, emit bit_tick on the last count, and clear on frame start.

Verification (CLK_FREQ=50_000_000, UART_BPS=115200, BPS_CNT=434)
REQ-031 PARITY=0, STOP_BITS=1, send 0x55 -> txd bits 0,1,0,1,0,1,0,1,0,1 at 434 cycles each; tx_busy high 4340 cycles; one tx_done pulse.
REQ-032 PARITY=2, send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0; tx_busy high 4774 cycles.
REQ-033 STOP_BITS=2, send 0xA3 -> stop high for 868 cycles; tx_busy high 4774 cycles.
REQ-034 Toggle send_en low->high at cycle 1000 of a frame with data 0xFF -> ignored; line shows only the first byte.
REQ-035 Assert sys_rst at cycle 2000 of a frame -> txd=1, tx_busy=0 same cycle; no tx_done pulse.
REQ-036 Hold send_en high for 20000 cycles -> exactly one frame, one tx_done pulse.
